// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: scans 4 digit slots onto one 7-seg bus with blanking and per-frame snapshots (optional LEADING_ZERO_BLANK_EN)
module seg_scan_scheduler #(
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anodes,
  output logic [3:0]  digit_out,
  output logic        dp_out,
  output logic        frame_start
);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [1:0] slot, slot_n, sel;
  logic found, wrap;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0] snap, snap_n;
  logic [3:0] snap_dp, snap_dp_n, an_n, dig_n, eff_live, eff_snap;
  logic dp_n, fs_n;
`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [3:0] eff_en(input logic [15:0] v, input logic [3:0] en);
    logic nz_above;
    nz_above = 1'b0;
    eff_en = en;
    for (int k = 3; k > 0; k--) begin
      eff_en[k] = en[k] & ((v[4*k +: 4] != 4'd0) | nz_above);
      nz_above = nz_above | (en[k] & (v[4*k +: 4] != 4'd0));
    end
  endfunction
  assign eff_live = eff_en(digits, digit_en);
  assign eff_snap = eff_en(snap, digit_en);
`else
  assign eff_live = digit_en;
  assign eff_snap = digit_en;
`endif
  // pick the first usable slot after the current one; a wrap (index <= slot) begins a new frame and uses live values
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    sel = slot;
    wrap = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      idx = slot + 2'(i);
      if ((idx <= slot) ? eff_live[idx] : eff_snap[idx]) begin
        found = 1'b1;
        sel = idx;
        wrap = idx <= slot;
      end
    end
  end
  // next-state and registered-output values for the BLANK/SHOW sequencer
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    slot_n = slot;
    an_n = anodes;
    dig_n = digit_out;
    dp_n = dp_out;
    fs_n = 1'b0;
    snap_n = snap;
    snap_dp_n = snap_dp;
    if (state == BLANK) begin
      if (cnt != CNT_W'(BLANK_CYC - 1)) cnt_n = cnt + 1'b1;
      else if (found) begin
        state_n = SHOW;
        cnt_n = '0;
        slot_n = sel;
        an_n = ~(4'b0001 << sel);
        fs_n = wrap;
        snap_n = wrap ? digits : snap;
        snap_dp_n = wrap ? dp_in : snap_dp;
        dig_n = wrap ? digits[{sel, 2'b00} +: 4] : snap[{sel, 2'b00} +: 4];
        dp_n = wrap ? dp_in[sel] : snap_dp[sel];
      end
    end else if (!digit_en[slot] || cnt == CNT_W'(SHOW_CYC - 1)) begin
      state_n = BLANK;
      cnt_n = '0;
      an_n = 4'b1111;
    end else cnt_n = cnt + 1'b1;
  end
  // state, counter, snapshot and output registers; reset blanks the anodes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      slot <= 2'd3;
      cnt <= '0;
      anodes <= 4'b1111;
      digit_out <= 4'd0;
      dp_out <= 1'b0;
      frame_start <= 1'b0;
      snap <= 16'd0;
      snap_dp <= 4'd0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      cnt <= cnt_n;
      anodes <= an_n;
      digit_out <= dig_n;
      dp_out <= dp_n;
      frame_start <= fs_n;
      snap <= snap_n;
      snap_dp <= snap_dp_n;
    end
  end
endmodule
